// File: rtl/cfg_pwm_timer.sv
// Prescaled PWM/timer driven by the register bank's flat config bus.
// Period and duty are shadowed and reloaded only at a wrap. A one-shot mode stops after a set number of periods.
module cfg_pwm_timer #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            pwm_out,
  output logic                            period_pulse
);

  localparam int CW = 2 * REG_WIDTH;
  localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0] REG_ONE = {{(REG_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [REG_WIDTH-1:0] r_psCnt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_perS;
  logic [CW-1:0]        r_dutS;
  logic [REG_WIDTH-1:0] r_repS;
  logic [REG_WIDTH-1:0] r_perCount;
  logic                 r_clrD;
  logic                 r_pwm;

  state_t               w_stateNext;
  logic [REG_WIDTH-1:0] w_psNext;
  logic [CW-1:0]        w_cntNext;
  logic [CW-1:0]        w_perSNext;
  logic [CW-1:0]        w_dutSNext;
  logic [REG_WIDTH-1:0] w_repSNext;
  logic [REG_WIDTH-1:0] w_perCountNext;
  logic                 w_pwmNext;
  logic                 w_pulse;

  logic                 w_en;
  logic                 w_oneshot;
  logic                 w_pol;
  logic                 w_clr;
  logic                 w_clrEdge;
  logic [REG_WIDTH-1:0] w_ps;
  logic [CW-1:0]        w_per;
  logic [CW-1:0]        w_dut;
  logic [REG_WIDTH-1:0] w_rep;
  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_clamp;
  logic                 w_unused;

  assign w_en      = config_regs[0];
  assign w_oneshot = config_regs[1];
  assign w_pol     = config_regs[2];
  assign w_clr     = config_regs[3];
  assign w_ps      = config_regs[1*REG_WIDTH +: REG_WIDTH];
  assign w_per     = config_regs[2*REG_WIDTH +: CW];
  assign w_dut     = config_regs[4*REG_WIDTH +: CW];
  assign w_rep     = config_regs[6*REG_WIDTH +: REG_WIDTH];
  assign w_unused  = ^{config_regs[REG_WIDTH-1:4], config_regs[NUM_CFG*REG_WIDTH-1:7*REG_WIDTH]};

  assign w_clrEdge = w_clr & ~r_clrD;
  // Compare with >= so that lowering PS below the running count cannot cause a long wrap-around.
  assign w_tick    = (r_psCnt >= w_ps);
  assign w_wrap    = (r_cnt == r_perS);
  assign w_clamp   = (r_dutS > r_perS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_stateNext;
    end
  end

  // Event priority inside RUN: EN low, then CLR edge, then tick/wrap. A one-shot finish replaces the shadow reload.
  always_comb begin
    w_stateNext    = r_state;
    w_psNext       = r_psCnt;
    w_cntNext      = r_cnt;
    w_perSNext     = r_perS;
    w_dutSNext     = r_dutS;
    w_repSNext     = r_repS;
    w_perCountNext = r_perCount;
    w_pwmNext      = r_pwm;
    w_pulse        = 1'b0;
    if (!w_en) begin
      w_stateNext = IDLE;
      w_psNext    = '0;
      w_cntNext   = '0;
      w_pwmNext   = w_pol;
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext    = RUN;
          w_psNext       = '0;
          w_cntNext      = '0;
          w_perSNext     = w_per;
          w_dutSNext     = w_dut;
          w_repSNext     = w_rep;
          w_perCountNext = '0;
          w_pwmNext      = w_pol;
        end
        RUN: begin
          w_pwmNext = (r_cnt < r_dutS) ^ w_pol;
          if (w_clrEdge) begin
            w_psNext       = '0;
            w_cntNext      = '0;
            w_perCountNext = '0;
            w_perSNext     = w_per;
            w_dutSNext     = w_dut;
            w_repSNext     = w_rep;
          end else if (w_tick) begin
            w_psNext = '0;
            if (w_wrap) begin
              w_cntNext      = '0;
              w_pulse        = 1'b1;
              w_perCountNext = r_perCount + REG_ONE;
              if (w_oneshot && (r_perCount == r_repS)) begin
                w_stateNext = DONE;
              end else begin
                w_perSNext = w_per;
                w_dutSNext = w_dut;
              end
            end else begin
              w_cntNext = r_cnt + CNT_ONE;
            end
          end else begin
            w_psNext = r_psCnt + REG_ONE;
          end
        end
        DONE: begin
          w_pwmNext = w_pol;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psCnt    <= '0;
      r_cnt      <= '0;
      r_perS     <= '0;
      r_dutS     <= '0;
      r_repS     <= '0;
      r_perCount <= '0;
      r_clrD     <= 1'b0;
      r_pwm      <= 1'b0;
    end else if (ena) begin
      r_psCnt    <= w_psNext;
      r_cnt      <= w_cntNext;
      r_perS     <= w_perSNext;
      r_dutS     <= w_dutSNext;
      r_repS     <= w_repSNext;
      r_perCount <= w_perCountNext;
      r_clrD     <= w_clr;
      r_pwm      <= w_pwmNext;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_pulse = ena & w_pulse;

  always_comb begin
    status_regs = '0;
    status_regs[0*REG_WIDTH +: REG_WIDTH] = {{(REG_WIDTH-2){1'b0}}, r_state};
    status_regs[1*REG_WIDTH +: CW]        = r_cnt;
    status_regs[3*REG_WIDTH +: REG_WIDTH] = r_perCount;
    status_regs[4*REG_WIDTH +: REG_WIDTH] = {{(REG_WIDTH-3){1'b0}}, w_clamp,
                                             (r_state == RUN), (r_state == DONE)};
  end

endmodule

// File: tb/tb_cfg_pwm_timer.sv
// Directed bench for cfg_pwm_timer. It compares waveforms and status bytes against values worked out by hand.
module tb_cfg_pwm_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic        pwm_out;
  logic        period_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] seq;
  int          pulses;

  always #5 clk = ~clk;

  cfg_pwm_timer #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .config_regs  (config_regs),
    .status_regs  (status_regs),
    .pwm_out      (pwm_out),
    .period_pulse (period_pulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ctrl, input logic [7:0] ps,
                               input logic [15:0] per, input logic [15:0] dutv,
                               input logic [7:0] rep);
    config_regs = {8'h00, rep, dutv, per, ps, ctrl};
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shifts one pwm_out sample per clock into seq, oldest sample in the MSB, and counts period pulses.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      seq = {seq[30:0], pwm_out};
      pulses += int'(period_pulse);
    end
  endtask

  function automatic logic [31:0] sByte(input int k);
    return {24'h0, status_regs[8*k +: 8]};
  endfunction

  function automatic logic [31:0] cntVal();
    return {16'h0, status_regs[23:8]};
  endfunction

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    applyStimulus(8'h00, 8'd0, 16'd0, 16'd0, 8'd0);
    step(2);
    checkOutput("reset_pwm", {31'h0, pwm_out}, 32'h0);
    checkOutput("reset_pulse", {31'h0, period_pulse}, 32'h0);
    checkOutput("reset_status_lo", status_regs[31:0], 32'h0);
    checkOutput("reset_status_hi", status_regs[63:32], 32'h0);
    rst = 1'b0;
    step(1);
    checkOutput("idle_state", sByte(0), 32'd0);

    // PS=0, PER=9, DUT=3: 3 clocks high and 7 clocks low in each period.
    applyStimulus(8'h01, 8'd0, 16'd9, 16'd3, 8'd0);
    step(1);
    checkOutput("a_state_run", sByte(0), 32'd1);
    checkOutput("a_cnt_start", cntVal(), 32'd0);
    seq = '0; pulses = 0;
    capture(20);
    checkOutput("a_pwm_seq", seq, 32'b11100000001110000000);
    checkOutput("a_pulses", pulses, 32'd2);
    checkOutput("a_period_count", sByte(3), 32'd2);
    checkOutput("a_flags", sByte(4), 32'h02);

    // PS=3, PER=4, DUT=2, POL=1: 20-clock period, 8 clocks low then 12 clocks high.
    applyStimulus(8'h04, 8'd3, 16'd4, 16'd2, 8'd0);
    step(1);
    checkOutput("b_idle_pol", {31'h0, pwm_out}, 32'h1);
    checkOutput("b_state_idle", sByte(0), 32'd0);
    applyStimulus(8'h05, 8'd3, 16'd4, 16'd2, 8'd0);
    step(1);
    checkOutput("b_state_run", sByte(0), 32'd1);
    seq = '0; pulses = 0;
    capture(24);
    checkOutput("b_pwm_seq", seq, 32'h00FFF0);
    checkOutput("b_pulses", pulses, 32'd1);
    checkOutput("b_period_count", sByte(3), 32'd1);

    // Changing DUT mid-period affects only the following period.
    applyStimulus(8'h00, 8'd0, 16'd9, 16'd3, 8'd0);
    step(1);
    applyStimulus(8'h01, 8'd0, 16'd9, 16'd3, 8'd0);
    step(1);
    seq = '0; pulses = 0;
    capture(5);
    applyStimulus(8'h01, 8'd0, 16'd9, 16'd7, 8'd0);
    capture(15);
    checkOutput("c_pwm_seq", seq, 32'b11100000001111111000);
    checkOutput("c_pulses", pulses, 32'd2);
    checkOutput("c_period_count", sByte(3), 32'd2);

    // One-shot with REP=1 runs exactly two periods and then parks in DONE.
    applyStimulus(8'h00, 8'd0, 16'd4, 16'd2, 8'd1);
    step(1);
    applyStimulus(8'h03, 8'd0, 16'd4, 16'd2, 8'd1);
    step(1);
    seq = '0; pulses = 0;
    capture(12);
    checkOutput("d_pwm_seq", seq, 32'b110001100000);
    checkOutput("d_pulses", pulses, 32'd2);
    checkOutput("d_state_done", sByte(0), 32'd2);
    checkOutput("d_flags_done", sByte(4), 32'h01);
    checkOutput("d_period_count", sByte(3), 32'd2);
    checkOutput("d_cnt_held", cntVal(), 32'd0);
    applyStimulus(8'h07, 8'd0, 16'd4, 16'd2, 8'd1);
    step(1);
    checkOutput("d_pol_in_done", {31'h0, pwm_out}, 32'h1);
    applyStimulus(8'h05, 8'd0, 16'd4, 16'd2, 8'd1);
    step(2);
    checkOutput("d_oneshot_clear_stays", sByte(0), 32'd2);
    applyStimulus(8'h04, 8'd0, 16'd4, 16'd2, 8'd1);
    step(1);
    checkOutput("d_en_low_idle", sByte(0), 32'd0);
    applyStimulus(8'h05, 8'd0, 16'd4, 16'd2, 8'd1);
    step(1);
    checkOutput("d_rearm_run", sByte(0), 32'd1);
    checkOutput("d_rearm_count", sByte(3), 32'd0);

    // DUT greater than PER clamps the output high and sets the clamp flag.
    applyStimulus(8'h00, 8'd0, 16'd9, 16'd20, 8'd0);
    step(1);
    applyStimulus(8'h01, 8'd0, 16'd9, 16'd20, 8'd0);
    step(1);
    seq = '0; pulses = 0;
    capture(12);
    checkOutput("e_pwm_high", seq, 32'hFFF);
    checkOutput("e_flags_clamp", sByte(4), 32'h06);
    checkOutput("e_upper_status", {8'h0, status_regs[63:40]}, 32'h0);
    checkOutput("e_period_count", sByte(3), 32'd1);
    checkOutput("e_cnt_before_clr", cntVal(), 32'd2);
    applyStimulus(8'h09, 8'd0, 16'd9, 16'd20, 8'd0);
    step(1);
    checkOutput("e_clr_cnt", cntVal(), 32'd0);
    checkOutput("e_clr_count", sByte(3), 32'd0);
    checkOutput("e_clr_state", sByte(0), 32'd1);
    step(1);
    checkOutput("e_clr_level_no_edge", cntVal(), 32'd1);
    applyStimulus(8'h01, 8'd0, 16'd9, 16'd20, 8'd0);
    step(1);
    checkOutput("e_cnt_after_clr", cntVal(), 32'd2);
    ena = 1'b0;
    step(5);
    checkOutput("e_ena_frozen_cnt", cntVal(), 32'd2);
    checkOutput("e_ena_pulse", {31'h0, period_pulse}, 32'h0);
    checkOutput("e_ena_pwm_hold", {31'h0, pwm_out}, 32'h1);
    ena = 1'b1;
    step(1);
    checkOutput("e_ena_resume_cnt", cntVal(), 32'd3);

    // Asynchronous reset applied between clock edges while RUN is active.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("r_async_pwm", {31'h0, pwm_out}, 32'h0);
    checkOutput("r_async_status_lo", status_regs[31:0], 32'h0);
    checkOutput("r_async_status_hi", status_regs[63:32], 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("r_released_idle", sByte(0), 32'd0);
    step(1);
    checkOutput("r_rerun_state", sByte(0), 32'd1);
    checkOutput("r_rerun_shadows", sByte(4), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
